// File: rtl/uio_arb_pkg.sv
// Shared types, defaults and width helpers for the uio pin-bank arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MAX_HOLD    = 8;
    localparam int DEF_TURN_CYCLES = 1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Explicit modulo add so non-power-of-two requester counts wrap correctly.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/uio_bank_arbiter_if.sv
// Requester-side and pin-side signal bundle of the uio pin-bank arbiter.
interface uio_bank_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = uio_arb_pkg::idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_dout;
    logic [NUM_REQ*8-1:0] req_oe;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;
    logic [7:0]           uio_in;
    logic [7:0]           rd_data;
    logic                 rd_valid;
    logic [IW-1:0]        rd_id;

    // Engines and pins: drive requests, pin data in; observe grant and pins.
    modport master (
        output req, req_dout, req_oe, uio_in,
        input  grant, uio_out, uio_oe, rd_data, rd_valid, rd_id
    );

    // Arbiter side.
    modport slave (
        input  req, req_dout, req_oe, uio_in,
        output grant, uio_out, uio_oe, rd_data, rd_valid, rd_id
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector so rr_ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    logic [NUM_REQ-1:0] rot;
    int                 enc;

    // Rotate so the current round-robin start position is bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[wrap_add(int'(rr_ptr), i, NUM_REQ)];
        end
    end

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        enc = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = i;
        end
        found = |rot;
        idx   = IW'(wrap_add(int'(rr_ptr), enc, NUM_REQ));
    end

endmodule

// File: rtl/uio_bank_arbiter.sv
// Round-robin owner arbitration for the shared 8-bit uio pin bank, with a
// bounded tenure while others wait and tri-stated turnaround between owners.
module uio_bank_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input logic               clk,
    input logic               rst,
    uio_bank_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int HW = cnt_w(MAX_HOLD);
    localparam int TW = cnt_w(TURN_CYCLES);

    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]      TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_REQ - 1);

    state_t             state, state_n;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      rr_ptr, rr_ptr_n;
    logic [HW-1:0]      hold_cnt, hold_cnt_n;
    logic [TW-1:0]      turn_cnt, turn_cnt_n;
    logic [NUM_REQ-1:0] grant, grant_n;

    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic               others_waiting;
    logic               release_now;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign owner_oh       = ONE << owner;
    assign others_waiting = |(bus.req & ~owner_oh);
    // Owner dropped its request, or its tenure is used up and someone is queued.
    assign release_now    = !bus.req[owner] || ((hold_cnt == HOLD_LAST) && others_waiting);

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            grant    <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            hold_cnt <= hold_cnt_n;
            turn_cnt <= turn_cnt_n;
            grant    <= grant_n;
        end
    end

    // Next-state, grant and counter decisions.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        hold_cnt_n = hold_cnt;
        turn_cnt_n = turn_cnt;
        grant_n    = grant;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (pick_found) begin
                    grant_n    = ONE << pick_idx;
                    owner_n    = pick_idx;
                    hold_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_n    = '0;
                    rr_ptr_n   = (owner == IDX_LAST) ? '0 : owner + 1'b1;
                    turn_cnt_n = '0;
                    state_n    = TURN;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            TURN: begin
                grant_n = '0;
                if (turn_cnt == TURN_LAST) begin
                    state_n = IDLE;
                end else begin
                    turn_cnt_n = turn_cnt + 1'b1;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.grant = grant;

    // Pin mux: only the registered owner drives, and only while in GRANT.
    always_comb begin
        bus.uio_out = '0;
        bus.uio_oe  = '0;
        if (state == GRANT) begin
            bus.uio_out = bus.req_dout[int'(owner)*8 +: 8];
            bus.uio_oe  = bus.req_oe[int'(owner)*8 +: 8];
        end
    end

    // Pin sample, tagged with whether an owner held the bus and which one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_id    <= '0;
        end else begin
            bus.rd_data  <= bus.uio_in;
            bus.rd_valid <= (state == GRANT);
            bus.rd_id    <= owner;
        end
    end

endmodule

// File: tb/tb_uio_bank_arbiter.sv
// Directed scoreboard bench for uio_bank_arbiter: stimulus queues the expected
// per-cycle view, a negedge monitor pops and compares it against the DUT.
module tb_uio_bank_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uio_bank_arbiter_if #(.NUM_REQ(4)) bus ();

    uio_bank_arbiter #(
        .NUM_REQ     (4),
        .MAX_HOLD    (8),
        .TURN_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] dout_v [4];
    logic [7:0] oe_v   [4];

    // Pack per-requester pin values onto the flat buses.
    always_comb begin
        bus.req_dout = '0;
        bus.req_oe   = '0;
        for (int k = 0; k < 4; k++) begin
            bus.req_dout[k*8 +: 8] = dout_v[k];
            bus.req_oe[k*8 +: 8]   = oe_v[k];
        end
    end

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic [7:0] uout;
        logic [7:0] uoe;
        bit         chk_rd;
        logic [7:0] rdd;
        logic       rdv;
        logic [1:0] rid;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic int oh_idx(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Queue the expected view for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic [3:0] g, input bit rd = 1'b0,
                       input logic [7:0] rdd = 8'h00, input logic rdv = 1'b0,
                       input logic [1:0] rid = 2'd0);
        exp_t e;
        e.name   = nm;
        e.grant  = g;
        e.uout   = (g == 4'b0) ? 8'h00 : dout_v[oh_idx(g)];
        e.uoe    = (g == 4'b0) ? 8'h00 : oe_v[oh_idx(g)];
        e.chk_rd = rd;
        e.rdd    = rdd;
        e.rdv    = rdv;
        e.rid    = rid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever expectation is pending for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            bit   bad;
            e = exp_q.pop_front();
            vectors++;
            bad = (bus.grant !== e.grant) || (bus.uio_out !== e.uout) || (bus.uio_oe !== e.uoe)
                  || ((bus.uio_oe != 8'h00) && (bus.grant == 4'b0));
            if (e.chk_rd)
                bad = bad || (bus.rd_data !== e.rdd) || (bus.rd_valid !== e.rdv) || (bus.rd_id !== e.rid);
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got grant=%b out=%h oe=%h rd=%h/%b/%0d, want grant=%b out=%h oe=%h rd=%h/%b/%0d (rd checked=%0d)",
                         e.name, bus.grant, bus.uio_out, bus.uio_oe, bus.rd_data, bus.rd_valid, bus.rd_id,
                         e.grant, e.uout, e.uoe, e.rdd, e.rdv, e.rid, e.chk_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        dout_v = '{8'h1F, 8'h2E, 8'hA5, 8'h4C};
        oe_v   = '{8'hFF, 8'h0F, 8'hF0, 8'h3C};
        bus.req    = 4'b0000;
        bus.uio_in = 8'h5A;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with all requests up: nothing granted.
        bus.req = 4'b1111;
        cyc("rst_hold", 4'b0000, 1, 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        cyc("rst_release", 4'b0000, 1, 8'h00, 1'b0, 2'd0);

        // Fairness: 8-cycle tenures in order 0,1,2,3,0 with TURN+IDLE gaps.
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 8; c++)
                cyc($sformatf("rr_t%0d_c%0d", t, c), 4'b0001 << order[t], c > 0, 8'h5A, 1'b1, 2'(order[t]));
            if (t == 4) bus.req = 4'b0000;
            cyc($sformatf("rr_turn%0d", t), 4'b0000, 1, 8'h5A, 1'b1, 2'(order[t]));
            cyc($sformatf("rr_idle%0d", t), 4'b0000, 1, 8'h5A, 1'b0, 2'(order[t]));
        end

        // Single requester, then release.
        bus.req = 4'b0100;
        cyc("sr_idle", 4'b0000);
        cyc("sr_g0", 4'b0100);
        cyc("sr_g1", 4'b0100);
        bus.req = 4'b0000;
        cyc("sr_drop", 4'b0100);
        cyc("sr_turn", 4'b0000, 1, 8'h5A, 1'b1, 2'd2);
        cyc("sr_idle2", 4'b0000, 1, 8'h5A, 1'b0, 2'd2);

        // Lone owner keeps the bus past MAX_HOLD; a newcomer forces handover.
        bus.req = 4'b0010;
        cyc("hs_idle", 4'b0000);
        for (int i = 0; i < 20; i++) cyc($sformatf("hs_hold%0d", i), 4'b0010);
        bus.req = 4'b1010;
        cyc("hs_raise", 4'b0010);
        cyc("hs_turn", 4'b0000);
        cyc("hs_idle2", 4'b0000);
        bus.req = 4'b0000;
        cyc("hs_g3", 4'b1000);
        cyc("hs_turn2", 4'b0000);
        cyc("hs_idle3", 4'b0000);

        // Read path: sample tagged with owner, then untagged after TURN.
        oe_v[0]    = 8'h00;
        bus.uio_in = 8'h3C;
        bus.req    = 4'b0001;
        cyc("rp_idle", 4'b0000);
        cyc("rp_grant", 4'b0001);
        bus.req    = 4'b0000;
        bus.uio_in = 8'hC3;
        cyc("rp_rd", 4'b0001, 1, 8'h3C, 1'b1, 2'd0);
        cyc("rp_turn", 4'b0000, 1, 8'hC3, 1'b1, 2'd0);
        cyc("rp_idle2", 4'b0000, 1, 8'hC3, 1'b0, 2'd0);
        oe_v[0] = 8'hFF;

        // Move rr_ptr to 2, then reset mid-grant; rr_ptr must return to 0.
        bus.req = 4'b0010;
        cyc("mg_idle", 4'b0000);
        bus.req = 4'b0000;
        cyc("mg_g1", 4'b0010);
        cyc("mg_turn", 4'b0000);
        bus.req = 4'b0100;
        cyc("mg_idle2", 4'b0000);
        cyc("mg_g2", 4'b0100);
        rst = 1'b1;
        cyc("mg_rst", 4'b0100);
        rst = 1'b0;
        bus.req = 4'b0110;
        cyc("mg_post", 4'b0000, 1, 8'h00, 1'b0, 2'd0);
        bus.req = 4'b0000;
        cyc("mg_rr", 4'b0010);
        cyc("end_turn", 4'b0000);
        cyc("end_idle", 4'b0000);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
